// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a bank of WIDTH JK cells.
// Optional build macro JK_MERGE_EN merges same-cell commands issued in the same cycle.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDXW-1:0]  req0_idx,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDXW-1:0]  req1_idx,
  input  logic [1:0]       req1_op,
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] q,
  output logic             idx_err
);

  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } ptr_e;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
    logic [1:0]      op;
  } cmd_t;

  ptr_e             ptr_q, ptr_d;
  cmd_t             cmd_q, cmd_d;
  logic [1:0]       grant_q, grant_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             idx_err_q, idx_err_d;
  logic             merge;

  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return 32'(idx) < 32'(WIDTH);
  endfunction

`ifdef JK_MERGE_EN
  assign merge = req0_valid && req1_valid && (req0_idx == req1_idx) && in_range(req0_idx);
`else
  assign merge = 1'b0;
`endif

  // Ready is forced low while rst is high so nothing is handshaken on a reset edge.
  assign req0_ready = !rst && req0_valid && (!req1_valid || ptr_q == PTR_REQ0 || merge);
  assign req1_ready = !rst && req1_valid && (!req0_valid || ptr_q == PTR_REQ1 || merge);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    ptr_d     = ptr_q;
    cmd_d     = '0;
    grant_d   = {req1_ready, req0_ready};
    q_d       = q_q;
    idx_err_d = idx_err_q;

    if (!merge) begin
      if (req0_ready)      ptr_d = PTR_REQ1;
      else if (req1_ready) ptr_d = PTR_REQ0;
    end

    cmd_d.valid = req0_ready || req1_ready;
    cmd_d.idx   = req0_ready ? req0_idx : req1_idx;
    cmd_d.op    = (req0_ready ? req0_op : 2'b00) | (req1_ready ? req1_op : 2'b00);

    if (cmd_d.valid && !in_range(cmd_d.idx)) idx_err_d = 1'b1;

    // Apply stage: the command accepted on the previous edge updates its cell only.
    if (cmd_q.valid && in_range(cmd_q.idx)) begin
      case (cmd_q.op)
        2'b01:   q_d[cmd_q.idx] = 1'b0;
        2'b10:   q_d[cmd_q.idx] = 1'b1;
        2'b11:   q_d[cmd_q.idx] = ~q_q[cmd_q.idx];
        default: q_d[cmd_q.idx] = q_q[cmd_q.idx];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= PTR_REQ0;
      cmd_q     <= '0;
      grant_q   <= 2'b00;
      q_q       <= '0;
      idx_err_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      cmd_q     <= cmd_d;
      grant_q   <= grant_d;
      q_q       <= q_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign grant   = grant_q;
  assign q       = q_q;
  assign idx_err = idx_err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench: vector table with a grant/q scoreboard plus hand-written corner sequences.
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, r0, r1;
  logic [2:0] i0, i1;
  logic [1:0] o0, o1;
  logic [1:0] grant;
  logic [7:0] q;
  logic       idx_err;

  logic       rst6;
  logic       v0_6, v1_6, r0_6, r1_6;
  logic [2:0] i0_6, i1_6;
  logic [1:0] o0_6, o1_6;
  logic [1:0] grant6;
  logic [5:0] q6;
  logic       idx_err6;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.WIDTH(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_idx(i0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(r1), .req1_idx(i1), .req1_op(o1),
    .grant(grant), .q(q), .idx_err(idx_err)
  );

  jk_bank_arbiter #(.WIDTH(6), .IDXW(3)) dut6 (
    .clk(clk), .rst(rst6),
    .req0_valid(v0_6), .req0_ready(r0_6), .req0_idx(i0_6), .req0_op(o0_6),
    .req1_valid(v1_6), .req1_ready(r1_6), .req1_idx(i1_6), .req1_op(o1_6),
    .grant(grant6), .q(q6), .idx_err(idx_err6)
  );

  typedef struct {
    logic       v0;
    logic [2:0] i0;
    logic [1:0] o0;
    logic       v1;
    logic [2:0] i1;
    logic [1:0] o1;
    logic       r0;
    logic       r1;
    logic [7:0] q;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] val;
  } sb_t;

  vec_t vecs[$];
  sb_t  gq[$];
  sb_t  qq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic a_v0, input logic [2:0] a_i0, input logic [1:0] a_o0,
                              input logic a_v1, input logic [2:0] a_i1, input logic [1:0] a_o1,
                              input logic a_r0, input logic a_r1, input logic [7:0] a_q);
    vec_t v;
    v.v0 = a_v0; v.i0 = a_i0; v.o0 = a_o0;
    v.v1 = a_v1; v.i1 = a_i1; v.o1 = a_o1;
    v.r0 = a_r0; v.r1 = a_r1; v.q = a_q;
    return v;
  endfunction

  task automatic compare_due();
    sb_t e;
    while (gq.size() > 0 && gq[0].due <= cyc) begin
      e = gq.pop_front();
      check("grant", 32'(grant), 32'(e.val));
    end
    while (qq.size() > 0 && qq[0].due <= cyc) begin
      e = qq.pop_front();
      check("q", 32'(q), 32'(e.val));
    end
  endtask

  task automatic idle8();
    v0 = 1'b0; i0 = '0; o0 = '0;
    v1 = 1'b0; i1 = '0; o1 = '0;
  endtask

  task automatic step(input vec_t v);
    sb_t e;
    @(negedge clk);
    cyc++;
    compare_due();
    v0 = v.v0; i0 = v.i0; o0 = v.o0;
    v1 = v.v1; i1 = v.i1; o1 = v.o1;
    #1;
    check("ready0", 32'(r0), 32'(v.r0));
    check("ready1", 32'(r1), 32'(v.r1));
    e.due = cyc + 1; e.val = {6'b0, v.r1, v.r0};
    gq.push_back(e);
    e.due = cyc + 2; e.val = v.q;
    qq.push_back(e);
  endtask

  task automatic drain();
    repeat (3) begin
      @(negedge clk);
      cyc++;
      compare_due();
      idle8();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle8();
    rst = 1'b1;
    rst6 = 1'b1;
    v0_6 = 1'b0; i0_6 = '0; o0_6 = '0;
    v1_6 = 1'b0; i1_6 = '0; o1_6 = '0;

    // Reset: ready must stay low while rst is high even with a valid request.
    @(negedge clk);
    v0 = 1'b1; i0 = 3'd1; o0 = 2'b10;
    #1 check("ready0_in_rst", 32'(r0), 32'd0);
    @(negedge clk);
    check("rst_q", 32'(q), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_idx_err", 32'(idx_err), 32'h0);
    rst = 1'b0; rst6 = 1'b0;
    idle8();

    // Single requester, toggle run with hold, contention, mixed ops.
    vecs.push_back(mk(1, 3, 2'b10, 0, 0, 2'b00, 1, 0, 8'h08));
    vecs.push_back(mk(1, 3, 2'b11, 0, 0, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mk(1, 3, 2'b01, 0, 0, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 2'b00, 1, 7, 2'b11, 0, 1, 8'h80));
    vecs.push_back(mk(0, 0, 2'b00, 1, 7, 2'b11, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 2'b00, 1, 7, 2'b11, 0, 1, 8'h80));
    vecs.push_back(mk(0, 0, 2'b00, 1, 7, 2'b11, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 2'b00, 1, 7, 2'b00, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 2'b10, 1, 4, 2'b10, 1, 0, 8'h01));
    vecs.push_back(mk(1, 1, 2'b10, 1, 4, 2'b10, 0, 1, 8'h11));
    vecs.push_back(mk(1, 1, 2'b10, 1, 5, 2'b10, 1, 0, 8'h13));
    vecs.push_back(mk(1, 2, 2'b10, 1, 5, 2'b10, 0, 1, 8'h33));
    vecs.push_back(mk(1, 2, 2'b10, 1, 6, 2'b10, 1, 0, 8'h37));
    vecs.push_back(mk(1, 3, 2'b10, 1, 6, 2'b10, 0, 1, 8'h77));
    vecs.push_back(mk(1, 3, 2'b10, 1, 7, 2'b10, 1, 0, 8'h7F));
    vecs.push_back(mk(0, 0, 2'b00, 1, 7, 2'b10, 0, 1, 8'hFF));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8'hFF));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8'hFF));
    vecs.push_back(mk(1, 5, 2'b01, 1, 6, 2'b11, 1, 0, 8'hDF));
    vecs.push_back(mk(1, 0, 2'b00, 1, 6, 2'b11, 0, 1, 8'h9F));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h9F));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8'h9F));

    for (int k = 0; k < vecs.size(); k++) step(vecs[k]);
    drain();

    // Reset mid-flight: the accepted command is discarded and the pointer returns to req0.
    @(negedge clk);
    v0 = 1'b1; i0 = 3'd2; o0 = 2'b10;
    #1 check("mid_ready0_accept", 32'(r0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("mid_ready0_in_rst", 32'(r0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b1; i0 = 3'd1; o0 = 2'b10;
    v1 = 1'b1; i1 = 3'd4; o1 = 2'b10;
    #1;
    check("mid_q_after_rst", 32'(q), 32'h0);
    check("mid_grant_after_rst", 32'(grant), 32'h0);
    check("mid_ptr_ready0", 32'(r0), 32'd1);
    check("mid_ptr_ready1", 32'(r1), 32'd0);
    @(negedge clk);
    idle8();
    check("mid_no_late_update", 32'(q), 32'h0);
    check("mid_grant_req0", 32'(grant), 32'h1);
    @(negedge clk);
    check("mid_q_next_cmd", 32'(q), 32'h02);

    // Out of range on a 6-cell bank.
    @(negedge clk);
    v0_6 = 1'b1; i0_6 = 3'd5; o0_6 = 2'b10;
    #1 check("oor_ready_idx5", 32'(r0_6), 32'd1);
    @(negedge clk);
    i0_6 = 3'd6; o0_6 = 2'b10;
    #1 check("oor_ready_idx6", 32'(r0_6), 32'd1);
    check("oor_err_before", 32'(idx_err6), 32'd0);
    @(negedge clk);
    i0_6 = 3'd7; o0_6 = 2'b11;
    #1 check("oor_err_set", 32'(idx_err6), 32'd1);
    check("oor_q_idx5", 32'(q6), 32'h20);
    check("oor_grant", 32'(grant6), 32'h1);
    @(negedge clk);
    v0_6 = 1'b1; i0_6 = 3'd6; o0_6 = 2'b10;
    v1_6 = 1'b1; i1_6 = 3'd6; o1_6 = 2'b01;
    #1 check("oor_no_merge", 32'(r0_6) + 32'(r1_6), 32'd1);
    check("oor_q_unchanged", 32'(q6), 32'h20);
    @(negedge clk);
    v0_6 = 1'b0; v1_6 = 1'b0;
    check("oor_q_still", 32'(q6), 32'h20);
    check("oor_err_sticky", 32'(idx_err6), 32'd1);
    rst6 = 1'b1;
    @(negedge clk);
    rst6 = 1'b0;
    check("oor_err_cleared", 32'(idx_err6), 32'd0);
    check("oor_q_cleared", 32'(q6), 32'h0);

`ifdef JK_MERGE_EN
    // Same-cell set+reset merges into a toggle, twice.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b1; i0 = 3'd5; o0 = 2'b10;
    v1 = 1'b1; i1 = 3'd5; o1 = 2'b01;
    #1 check("merge_ready0", 32'(r0), 32'd1);
    check("merge_ready1", 32'(r1), 32'd1);
    @(negedge clk);
    check("merge_grant", 32'(grant), 32'h3);
    @(negedge clk);
    idle8();
    check("merge_q_toggle1", 32'(q), 32'h20);
    check("merge_grant2", 32'(grant), 32'h3);
    @(negedge clk);
    check("merge_q_toggle2", 32'(q), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of WIDTH JK flip-flop cells between two command requesters.
- Each requester issues a (bit index, JK op) command over a valid/ready handshake.
- A round-robin arbiter grants at most one command per cycle. The granted command passes through a one-stage command register, then is applied to the addressed cell with standard JK semantics.
- Sits between control FSMs and the JK state bank; q is the bank state for downstream logic.

Parameters:
- WIDTH, 8: number of JK cells in the bank, 2..256.
- IDXW, 3: index width; must satisfy 2**IDXW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 command valid
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_idx  input  IDXW  requester 0 target cell
- req0_op  input  2  requester 0 op, {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
- req1_valid  input  1  requester 1 command valid
- req1_ready  output  1  requester 1 command accepted this cycle
- req1_idx  input  IDXW  requester 1 target cell
- req1_op  input  2  requester 1 op, same encoding as req0_op
- grant  output  2  one-hot, registered: requester accepted on the previous cycle; 00 if none
- q  output  WIDTH  bank state
- idx_err  output  1  sticky: an out-of-range index has been accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - q = 0, grant = 00, idx_err = 0.
  - Command register invalid.
  - Round-robin pointer favours req0.
- Readiness: req*_ready is combinational from the valid inputs and the pointer. The bank never stalls, so at most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the pointer side is granted, and the pointer moves to the other side.
  - Single grant: the pointer moves to the non-granted side.
  - No valid: pointer unchanged.
- Accept: at the edge where valid && ready, {idx, op, requester} is captured into the command register, and grant is set one-hot.
- Apply: on the following edge the registered command updates q[idx]:
  - 00: unchanged
  - 01: 0
  - 10: 1
  - 11: ~q[idx]
  - All other bits of q are unchanged.
- Latency:
  - Command visible on q exactly 2 edges after valid is first presented with ready high.
  - Sustained throughput is 1 command per cycle.
  - Back-to-back commands to the same cell apply in acceptance order.
- Out of range: idx >= WIDTH is still accepted and handshaken. q is not modified; idx_err is set and stays set until rst.
- Hold op (00): consumes a grant and a pointer advance with no effect on q.
- Reset mid-operation: rst overrides everything on that edge.
  - The in-flight command register is discarded, not applied.
  - q = 0, pointer returns to req0, ready stays low during the rst cycle.
- Requester obligation: a requester keeps idx/op stable while valid && !ready. The block does not check this.

Optional Feature:
- Macro: JK_MERGE_EN.
- Defined:
  - When both requesters are valid with equal in-range idx, both are readied in the same cycle and grant = 11.
  - The ops are merged bitwise: j = j0|j1, k = k0|k1. Examples: set+reset gives toggle; hold+set gives set.
  - The pointer is unchanged on a merge.
  - Out-of-range equal indices are not merged; normal arbitration applies.
- Undefined: normal round-robin only, grant is never 11, and the req ports are unchanged.

Test Plan:
- Reset and single requester (WIDTH=8):
  - Assert rst for 2 cycles, then check q=00, grant=00, idx_err=0.
  - req0 set idx3, then toggle idx3, then reset idx3, back to back. Check q[3] goes 1, 0, 0 on consecutive cycles, starting 2 edges after the first valid.
- Contention fairness:
  - Both requesters continuously valid, req0 setting idx0..3 and req1 setting idx4..7.
  - Check grant alternates 01, 10, 01, ... and all 8 bits are 1 after 9 cycles.
- Toggle sequence: req1 toggles idx7 four times back to back. Check q[7] = 1, 0, 1, 0, and the hold op leaves q unchanged while grant still pulses.
- Out of range (WIDTH=6, IDXW=3):
  - req0 set idx6. Check ready=1, q unchanged, idx_err=1 next cycle.
  - Then apply rst. Check idx_err=0.
- Reset mid-flight: accept req0 set idx2, then assert rst on the next edge. Check q[2]=0 after the rst cycle and no late update.
- JK_MERGE_EN build: req0 set idx5 and req1 reset idx5 in the same cycle with q[5]=0. Check both ready, grant=11, and q[5]=1 (toggle); the repeated merge gives q[5]=0.
